// File: rtl/fpu_result_uart_tx.sv
// FPU result return path: a small FIFO of 16-bit results, each sent as two UART frames, low byte first.
// Define FPU_TX_PARITY_EN to insert an even-parity bit after the data bits of every frame.
module fpu_result_uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic [15:0] CLKS_PER_BIT,
    input  logic        result_valid,
    input  logic [15:0] result_data,
    output logic        result_ready,
    output logic        o_Tx_Serial,
    output logic        o_Tx_Active,
    output logic        o_Tx_Done,
    output logic        fifo_overflow
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef FPU_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [15:0]        fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic [2:0]  state;
    logic [15:0] hold;
    logic        byte_sel;
    logic [2:0]  bit_idx;
    logic [15:0] baud_cnt;
    logic [15:0] bit_len;
    logic [15:0] cpb_eff;
    logic        bit_end;
    logic [7:0]  cur_byte;
    logic        line_next;
    logic        done_next;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign result_ready = !full;
    assign push         = result_valid && !full;
    assign pop          = (state == ST_IDLE) && !empty;

    assign cpb_eff  = (CLKS_PER_BIT == 16'd0) ? 16'd1 : CLKS_PER_BIT;
    assign bit_end  = (baud_cnt == bit_len - 16'd1);
    assign cur_byte = byte_sel ? hold[15:8] : hold[7:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= result_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (result_valid && full) begin
                fifo_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            baud_cnt <= '0;
        end else if (state == ST_IDLE || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    // Bit length is sampled only when a byte starts, so CLKS_PER_BIT never changes mid-byte.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= ST_IDLE;
            hold     <= '0;
            byte_sel <= 1'b0;
            bit_idx  <= '0;
            bit_len  <= 16'd1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        hold     <= fifo_mem[rd_ptr];
                        byte_sel <= 1'b0;
                        bit_len  <= cpb_eff;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef FPU_TX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef FPU_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        if (!byte_sel) begin
                            byte_sel <= 1'b1;
                            bit_len  <= cpb_eff;
                            state    <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        line_next = 1'b1;
        case (state)
            ST_START:  line_next = 1'b0;
            ST_DATA:   line_next = cur_byte[bit_idx];
`ifdef FPU_TX_PARITY_EN
            ST_PARITY: line_next = ^cur_byte;
`endif
            default:   line_next = 1'b1;
        endcase
    end

    assign done_next = (state == ST_STOP) && bit_end && byte_sel;

    // Outputs are registered together so line, active and done stay cycle-aligned.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Serial <= line_next;
            o_Tx_Active <= (state != ST_IDLE);
            o_Tx_Done   <= done_next;
        end
    end

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Directed bench for fpu_result_uart_tx: frame bits, timing, FIFO overflow, reset abort, zero divisor, loopback decode.
// Also builds with FPU_TX_PARITY_EN, where the parity-frame vector replaces the plain one.
module tb_fpu_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [15:0] cpb;
    logic        result_valid;
    logic [15:0] result_data;
    logic        result_ready;
    logic        tx_serial;
    logic        tx_active;
    logic        tx_done;
    logic        fifo_overflow;

`ifdef FPU_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    int checks   = 0;
    int failures = 0;

    int active_total = 0;
    int done_total   = 0;
    int done_mark    = 0;

    int         rx_n = 4;
    logic [7:0] rx_q [$];
    logic [7:0] rx_byte;

    always #5 clk = ~clk;

    fpu_result_uart_tx #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .CLKS_PER_BIT (cpb),
        .result_valid (result_valid),
        .result_data  (result_data),
        .result_ready (result_ready),
        .o_Tx_Serial  (tx_serial),
        .o_Tx_Active  (tx_active),
        .o_Tx_Done    (tx_done),
        .fifo_overflow(fifo_overflow)
    );

    always @(negedge clk) begin
        if (tx_active) begin
            active_total <= active_total + 1;
        end
        if (tx_done) begin
            done_total <= done_total + 1;
            done_mark  <= active_total + (tx_active ? 1 : 0);
        end
    end

    // Software UART receiver: samples mid-bit and queues each byte with a good stop bit.
    always begin : rx_mon
        @(negedge clk);
        if (rst_l && tx_serial == 1'b0) begin
            repeat (rx_n / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (rx_n) @(negedge clk);
                rx_byte[i] = tx_serial;
            end
            repeat (rx_n * (FRAME_BITS - 9)) @(negedge clk);
            if (tx_serial) begin
                rx_q.push_back(rx_byte);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the push happens on the following posedge.
    task automatic applyStimulus(input logic [15:0] data);
        result_valid = 1'b1;
        result_data  = data;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic checkSerial(input logic [21:0] bits, input int nbits, input int n, input string tag);
        for (int j = 0; j < nbits; j++) begin
            checkOutput($sformatf("%s_bit%0d_first", tag, j), 32'(tx_serial), 32'(bits[j]));
            if (n > 1) begin
                waitCycles(n - 1);
                checkOutput($sformatf("%s_bit%0d_last", tag, j), 32'(tx_serial), 32'(bits[j]));
            end
            waitCycles(1);
        end
    endtask

    task automatic checkRx(input int idx, input logic [7:0] expected, input string tag);
        logic [7:0] got;
        got = (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
        checkOutput(tag, 32'(got), 32'(expected));
    endtask

    initial begin : stim
        int a0;
        int d0;
        int base;
        int bad;
        logic [21:0] pair;

        rst_l        = 1'b0;
        cpb          = 16'd4;
        result_valid = 1'b0;
        result_data  = 16'h0000;
        waitCycles(3);
        checkOutput("rst_serial", 32'(tx_serial), 32'd1);
        checkOutput("rst_active", 32'(tx_active), 32'd0);
        checkOutput("rst_done", 32'(tx_done), 32'd0);
        checkOutput("rst_overflow", 32'(fifo_overflow), 32'd0);
        checkOutput("rst_ready", 32'(result_ready), 32'd1);
        rst_l = 1'b1;
        waitCycles(3);

`ifdef FPU_TX_PARITY_EN
        $display("[TB] parity frames, N=8, result 0x015A");
        cpb  = 16'd8;
        rx_n = 8;
        waitCycles(2);
        a0   = active_total;
        d0   = done_total;
        base = rx_q.size();
        applyStimulus(16'h015A);
        checkOutput("t5_idle0", 32'(tx_serial), 32'd1);
        waitCycles(1);
        checkOutput("t5_idle1", 32'(tx_serial), 32'd1);
        waitCycles(1);
        checkSerial(22'b11000000010_10010110100, 22, 8, "t5");
        waitCycles(2);
        checkOutput("t5_active_len", 32'(active_total - a0), 32'd176);
        checkOutput("t5_done_count", 32'(done_total - d0), 32'd1);
        checkOutput("t5_done_pos", 32'(done_mark - a0), 32'd176);
        checkRx(base, 8'h5A, "t5_rx_lo");
        checkRx(base + 1, 8'h01, "t5_rx_hi");
`else
        $display("[TB] 8N1 frames, N=4, result 0x3C5A");
        cpb  = 16'd4;
        rx_n = 4;
        a0   = active_total;
        d0   = done_total;
        base = rx_q.size();
        applyStimulus(16'h3C5A);
        checkOutput("t1_idle0", 32'(tx_serial), 32'd1);
        waitCycles(1);
        checkOutput("t1_idle1", 32'(tx_serial), 32'd1);
        waitCycles(1);
        checkSerial(20'b1001111000_1010110100, 20, 4, "t1");
        waitCycles(2);
        checkOutput("t1_active_len", 32'(active_total - a0), 32'd80);
        checkOutput("t1_done_count", 32'(done_total - d0), 32'd1);
        checkOutput("t1_done_pos", 32'(done_mark - a0), 32'd80);
        checkRx(base, 8'h5A, "t1_rx_lo");
        checkRx(base + 1, 8'h3C, "t1_rx_hi");
`endif

        $display("[TB] FIFO fill and overflow, N=2");
        cpb  = 16'd2;
        rx_n = 2;
        waitCycles(4);
        base = rx_q.size();
        applyStimulus(16'h1111);
        waitCycles(3);
        checkOutput("t2_ready_empty", 32'(result_ready), 32'd1);
        applyStimulus(16'h2222);
        checkOutput("t2_ready_1", 32'(result_ready), 32'd1);
        applyStimulus(16'h3333);
        checkOutput("t2_ready_2", 32'(result_ready), 32'd1);
        applyStimulus(16'h4444);
        checkOutput("t2_ready_3", 32'(result_ready), 32'd1);
        applyStimulus(16'h5555);
        checkOutput("t2_ready_full", 32'(result_ready), 32'd0);
        checkOutput("t2_ovf_before", 32'(fifo_overflow), 32'd0);
        applyStimulus(16'h6666);
        checkOutput("t2_ovf_set", 32'(fifo_overflow), 32'd1);
        checkOutput("t2_ready_still_full", 32'(result_ready), 32'd0);
        for (int k = 0; k < 1500 && rx_q.size() < base + 10; k++) begin
            waitCycles(1);
        end
        waitCycles(4);
        checkOutput("t2_rx_count", 32'(rx_q.size() - base), 32'd10);
        checkRx(base + 0, 8'h11, "t2_rx0");
        checkRx(base + 1, 8'h11, "t2_rx1");
        checkRx(base + 2, 8'h22, "t2_rx2");
        checkRx(base + 3, 8'h22, "t2_rx3");
        checkRx(base + 4, 8'h33, "t2_rx4");
        checkRx(base + 5, 8'h33, "t2_rx5");
        checkRx(base + 6, 8'h44, "t2_rx6");
        checkRx(base + 7, 8'h44, "t2_rx7");
        checkRx(base + 8, 8'h55, "t2_rx8");
        checkRx(base + 9, 8'h55, "t2_rx9");
        checkOutput("t2_ovf_sticky", 32'(fifo_overflow), 32'd1);
        checkOutput("t2_ready_drained", 32'(result_ready), 32'd1);

        $display("[TB] reset during DATA bit 3, N=4");
        cpb  = 16'd4;
        rx_n = 4;
        waitCycles(4);
        applyStimulus(16'h00F0);
        applyStimulus(16'h1111);
        waitCycles(18);
        checkOutput("t3_pre_serial", 32'(tx_serial), 32'd0);
        checkOutput("t3_pre_active", 32'(tx_active), 32'd1);
        #2;
        rst_l = 1'b0;
        #1;
        checkOutput("t3_rst_serial", 32'(tx_serial), 32'd1);
        checkOutput("t3_rst_active", 32'(tx_active), 32'd0);
        checkOutput("t3_rst_ready", 32'(result_ready), 32'd1);
        checkOutput("t3_rst_overflow", 32'(fifo_overflow), 32'd0);
        waitCycles(2);
        rst_l = 1'b1;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            waitCycles(1);
            if (tx_serial !== 1'b1 || tx_active !== 1'b0) begin
                bad++;
            end
        end
        checkOutput("t3_line_quiet", 32'(bad), 32'd0);
        checkOutput("t3_ready_after", 32'(result_ready), 32'd1);

        $display("[TB] CLKS_PER_BIT=0, result 0x00FF");
        cpb  = 16'd0;
        rx_n = 1;
        waitCycles(2);
        a0   = active_total;
        d0   = done_total;
        base = rx_q.size();
        applyStimulus(16'h00FF);
        checkOutput("t4_idle0", 32'(tx_serial), 32'd1);
        waitCycles(1);
        checkOutput("t4_idle1", 32'(tx_serial), 32'd1);
        waitCycles(1);
`ifdef FPU_TX_PARITY_EN
        pair = 22'b10000000000_10111111110;
`else
        pair = 22'(20'b1000000000_1111111110);
`endif
        checkSerial(pair, 2 * FRAME_BITS, 1, "t4");
        waitCycles(2);
        checkOutput("t4_active_len", 32'(active_total - a0), 32'(2 * FRAME_BITS));
        checkOutput("t4_done_count", 32'(done_total - d0), 32'd1);
        checkRx(base, 8'hFF, "t4_rx_lo");
        checkRx(base + 1, 8'h00, "t4_rx_hi");

        $display("[TB] loopback N=16, result 0xBEEF, divisor disturbed mid-byte");
        cpb  = 16'd16;
        rx_n = 16;
        waitCycles(4);
        base = rx_q.size();
        applyStimulus(16'hBEEF);
        waitCycles(20);
        cpb = 16'd5;
        waitCycles(60);
        cpb = 16'd16;
        for (int k = 0; k < 800 && rx_q.size() < base + 2; k++) begin
            waitCycles(1);
        end
        waitCycles(4);
        checkOutput("t6_rx_count", 32'(rx_q.size() - base), 32'd2);
        checkRx(base, 8'hEF, "t6_rx_lo");
        checkRx(base + 1, 8'hBE, "t6_rx_hi");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
